flac_frame_sequencer: RTL
=========================

FLAC_FRAME_SEQUENCER -- requirements
Module: flac_frame_sequencer

Interface
REQ-001 The block SHALL have parameter BLOCK_SIZE, default 4096, giving samples per frame (power of two, 16..4096).
REQ-002 The block SHALL have parameter MAX_INFLIGHT, default 2, giving frames admitted but not yet fully residual-encoded (1..3).
REQ-003 The block SHALL have port iClock  input  1  sole clock, rising edge.
REQ-004 The block SHALL have port iReset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port iEnable  input  1  global advance qualifier; when low all state holds.
REQ-006 The block SHALL have port iSample  input  16  signed source PCM sample.
REQ-007 The block SHALL have port iValid  input  1  source sample valid.
REQ-008 The block SHALL have port oReady  output  1  sequencer accepts iSample this cycle.
REQ-009 The block SHALL have port oSample  output  16  signed sample forwarded to the encoder pipeline.
REQ-010 The block SHALL have port oValid  output  1  oSample valid.
REQ-011 The block SHALL have port oFrameStart  output  1  pulse coincident with the first forwarded sample of a frame.
REQ-012 The block SHALL have port oFrameEnd  output  1  pulse coincident with the last forwarded sample of a frame.
REQ-013 The block SHALL have port iModelDone  input  1  single-cycle pulse from model search: LPC model for the oldest pending frame is ready.
REQ-014 The block SHALL have port iResValid  input  1  one residual emitted by the encode stage.
REQ-015 The block SHALL have port oFrameDone  output  1  pulse when the oldest in-flight frame has produced BLOCK_SIZE residuals.
REQ-016 The block SHALL have port oFrameIdx  output  8  index of the frame currently being admitted, wraps 255->0.
REQ-017 The block SHALL have port oInFlight  output  2  number of frames in flight.
REQ-018 The block SHALL have port oError  output  1  sticky protocol-error flag.

Function
REQ-019 A sample SHALL transfer when iEnable, iValid and oReady are all high; oSample/oValid SHALL be registered, one cycle after transfer.
REQ-020 The FSM SHALL have states IDLE (no frame open), STREAM (frame open, admitting), STALL (frame boundary reached, oInFlight == MAX_INFLIGHT).
REQ-021 IDLE->STREAM on the first transfer; oFrameStart SHALL assert with that sample's oValid.
REQ-022 A 12-bit sample counter SHALL count transfers in the open frame; on transfer BLOCK_SIZE-1 it SHALL wrap to 0, assert oFrameEnd, and increment oFrameIdx.
REQ-023 oInFlight SHALL increment at each frame start, decrement at each oFrameDone; if both occur in one cycle it SHALL remain unchanged.
REQ-024 oReady SHALL be low in STALL and whenever a new frame would start with oInFlight == MAX_INFLIGHT; otherwise high (IDLE or STREAM).
REQ-025 STREAM->STALL after oFrameEnd when oInFlight == MAX_INFLIGHT; STALL->IDLE on the cycle oFrameDone lowers oInFlight; STREAM->IDLE after oFrameEnd otherwise.
REQ-026 A pending-model counter SHALL increment per frame end and decrement per iModelDone; iModelDone with counter 0 SHALL set oError and be ignored.
REQ-027 A residual counter SHALL count iResValid; iResValid while pending-model count equals oInFlight (no model loaded) SHALL set oError and not count.
REQ-028 When the residual counter reaches BLOCK_SIZE-1 with iResValid, it SHALL wrap to 0 and oFrameDone SHALL pulse the next cycle.
REQ-029 iResValid with oInFlight == 0 SHALL set oError.
REQ-030 oError SHALL clear only on reset.

Reset
REQ-031 While iReset is low: state IDLE; all counters 0; oReady 0; oValid, oFrameStart, oFrameEnd, oFrameDone, oError 0; oSample 0; oFrameIdx 0; oInFlight 0.
REQ-032 Reset assertion mid-frame SHALL abandon all in-flight frames without emitting oFrameDone; oReady SHALL rise the first cycle after deassertion.

Structure
REQ-033 BLOCK_SIZE default, counter widths and FSM state encodings SHALL live in a shared package flac_pkg.
REQ-034 Residual-side accounting (residual counter, pending-model counter, oFrameDone, error detection) SHALL be one sub-module flac_frame_tracker.

Verification
REQ-035 BLOCK_SIZE=16, 40 back-to-back valid samples -> oFrameStart at samples 0,16,32; oFrameEnd at 15,31; oFrameIdx 0->1->2.
REQ-036 MAX_INFLIGHT=2, no iResValid, continuous input -> oReady low after sample 31, state STALL, oInFlight=2.
REQ-037 From REQ-036 state, iModelDone then 16 iResValid -> oFrameDone pulse, oInFlight 1, oReady high next cycle.
REQ-038 Frame end and final residual of oldest frame in the same cycle -> oInFlight unchanged, no stall.
REQ-039 iModelDone with no pending frame, or iResValid before any iModelDone -> oError=1 and stays 1 until reset.
REQ-040 Reset asserted at sample 7 of frame 3 -> all outputs per REQ-031 immediately; next input starts frame 0 with oFrameStart.

Source files
------------

// File: rtl/flac_pkg.sv
// Shared widths, defaults and FSM encodings for the FLAC frame sequencer and its residual tracker.
package flac_pkg;

    localparam int FLAC_BLOCK_SIZE = 4096;
    localparam int SAMPLE_W        = 16;
    localparam int CNT_W           = 12;
    localparam int INFLIGHT_W      = 2;
    localparam int FRAME_IDX_W     = 8;

    // Kept as plain vectors so older netlists/probes can match the encodings.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_STALL  = 2'd2;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] sample;
        logic                       first;
        logic                       last;
    } fwd_beat_t;

    function automatic logic [CNT_W-1:0] last_count(input int block_size);
        return CNT_W'(block_size - 1);
    endfunction

endpackage

// File: rtl/flac_frame_sequencer_if.sv
// PCM handshake into the sequencer and the framed sample stream out to the encoder pipeline.
interface flac_frame_sequencer_if;
    import flac_pkg::*;

    logic signed [SAMPLE_W-1:0] iSample;
    logic                       iValid;
    logic                       oReady;
    logic signed [SAMPLE_W-1:0] oSample;
    logic                       oValid;
    logic                       oFrameStart;
    logic                       oFrameEnd;

    modport master (
        output iSample, iValid,
        input  oReady, oSample, oValid, oFrameStart, oFrameEnd
    );

    modport slave (
        input  iSample, iValid,
        output oReady, oSample, oValid, oFrameStart, oFrameEnd
    );

endinterface

// File: rtl/flac_frame_tracker.sv
// Residual-side accounting: pending LPC models, residuals of the oldest frame, frame-done pulse, sticky error.
module flac_frame_tracker
    import flac_pkg::*;
#(
    parameter int BLOCK_SIZE = FLAC_BLOCK_SIZE
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iEnable,
    input  logic                  frame_end,
    input  logic                  iModelDone,
    input  logic                  iResValid,
    input  logic [INFLIGHT_W-1:0] in_flight,
    output logic                  frame_done_next,
    output logic                  oFrameDone,
    output logic                  oError
);

    localparam logic [CNT_W-1:0] RES_LAST = last_count(BLOCK_SIZE);

    logic [CNT_W-1:0]      res_cnt_reg;
    logic [INFLIGHT_W-1:0] pending_reg;
    logic                  done_reg;
    logic                  error_reg;
    logic                  model_take;
    logic                  model_err;
    logic                  res_take;
    logic                  res_err;

    // A residual is only legal once the oldest in-flight frame has its model.
    always_comb begin
        model_take      = 1'b0;
        model_err       = 1'b0;
        res_take        = 1'b0;
        res_err         = 1'b0;
        frame_done_next = 1'b0;
        if (iEnable) begin
            model_take      = iModelDone && (pending_reg != '0);
            model_err       = iModelDone && (pending_reg == '0);
            res_err         = iResValid && ((in_flight == '0) || (pending_reg == in_flight));
            res_take        = iResValid && !res_err;
            frame_done_next = res_take && (res_cnt_reg == RES_LAST);
        end
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            res_cnt_reg <= '0;
            pending_reg <= '0;
            done_reg    <= 1'b0;
            error_reg   <= 1'b0;
        end else if (iEnable) begin
            pending_reg <= pending_reg + INFLIGHT_W'(frame_end) - INFLIGHT_W'(model_take);
            if (res_take) begin
                res_cnt_reg <= frame_done_next ? '0 : res_cnt_reg + CNT_W'(1);
            end
            done_reg <= frame_done_next;
            if (model_err || res_err) begin
                error_reg <= 1'b1;
            end
        end
    end

    assign oFrameDone = done_reg;
    assign oError     = error_reg;

endmodule

// File: rtl/flac_frame_sequencer.sv
// Cuts the PCM stream into BLOCK_SIZE frames and throttles admission to MAX_INFLIGHT unfinished frames.
module flac_frame_sequencer
    import flac_pkg::*;
#(
    parameter int BLOCK_SIZE   = FLAC_BLOCK_SIZE,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                   iClock,
    input  logic                   iReset,
    input  logic                   iEnable,
    flac_frame_sequencer_if.slave  pcm,
    input  logic                   iModelDone,
    input  logic                   iResValid,
    output logic                   oFrameDone,
    output logic [FRAME_IDX_W-1:0] oFrameIdx,
    output logic [INFLIGHT_W-1:0]  oInFlight,
    output logic                   oError
);

    localparam logic [CNT_W-1:0]      SMP_LAST     = last_count(BLOCK_SIZE);
    localparam logic [INFLIGHT_W-1:0] INFLIGHT_MAX = INFLIGHT_W'(MAX_INFLIGHT);

    logic [1:0]             state_reg;
    logic [1:0]             state_next;
    logic [CNT_W-1:0]       smp_cnt_reg;
    logic [FRAME_IDX_W-1:0] idx_reg;
    logic [INFLIGHT_W-1:0]  inflight_reg;
    logic [INFLIGHT_W-1:0]  inflight_next;
    logic                   live_reg;
    logic                   valid_reg;
    fwd_beat_t              beat_reg;

    logic ready;
    logic xfer;
    logic frame_start;
    logic frame_end;
    logic frame_done_next;

    // live_reg keeps oReady low through reset and releases it on the first clock after.
    assign ready = live_reg
                 && (state_reg != ST_STALL)
                 && !((state_reg == ST_IDLE) && (inflight_reg == INFLIGHT_MAX));

    assign xfer          = iEnable && pcm.iValid && ready;
    assign frame_start   = xfer && (state_reg == ST_IDLE);
    assign frame_end     = xfer && (smp_cnt_reg == SMP_LAST);
    assign inflight_next = inflight_reg + INFLIGHT_W'(frame_start) - INFLIGHT_W'(frame_done_next);

    // A frame finishing its residuals on the closing cycle frees the slot, so no stall.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (frame_start) state_next = ST_STREAM;
            end
            ST_STREAM: begin
                if (frame_end) state_next = (inflight_next == INFLIGHT_MAX) ? ST_STALL : ST_IDLE;
            end
            ST_STALL: begin
                if (frame_done_next) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_reg    <= ST_IDLE;
            smp_cnt_reg  <= '0;
            idx_reg      <= '0;
            inflight_reg <= '0;
            live_reg     <= 1'b0;
            valid_reg    <= 1'b0;
            beat_reg     <= '0;
        end else begin
            live_reg <= 1'b1;
            if (iEnable) begin
                state_reg      <= state_next;
                inflight_reg   <= inflight_next;
                valid_reg      <= xfer;
                beat_reg.first <= frame_start;
                beat_reg.last  <= frame_end;
                if (xfer) begin
                    beat_reg.sample <= pcm.iSample;
                    smp_cnt_reg     <= frame_end ? '0 : smp_cnt_reg + CNT_W'(1);
                end
                if (frame_end) begin
                    idx_reg <= idx_reg + FRAME_IDX_W'(1);
                end
            end
        end
    end

    flac_frame_tracker #(
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_tracker (
        .iClock          (iClock),
        .iReset          (iReset),
        .iEnable         (iEnable),
        .frame_end       (frame_end),
        .iModelDone      (iModelDone),
        .iResValid       (iResValid),
        .in_flight       (inflight_reg),
        .frame_done_next (frame_done_next),
        .oFrameDone      (oFrameDone),
        .oError          (oError)
    );

    assign pcm.oReady      = ready;
    assign pcm.oSample     = beat_reg.sample;
    assign pcm.oValid      = valid_reg;
    assign pcm.oFrameStart = beat_reg.first;
    assign pcm.oFrameEnd   = beat_reg.last;
    assign oFrameIdx       = idx_reg;
    assign oInFlight       = inflight_reg;

endmodule
